// File: rtl/rockband_pkg.sv
// Shared types and defaults for the note-judging slice: lane count, grade and
// game-state encodings, default scoring constants and small helpers.
package rockband_pkg;

  localparam int NUM_LANES = 4;

  localparam int ZONE_W_DEF      = 16;
  localparam int CENTER_TOL_DEF  = 3;
  localparam int PTS_PERFECT_DEF = 100;
  localparam int PTS_GOOD_DEF    = 50;
  localparam int SCORE_W_DEF     = 20;
  localparam int STREAK_W_DEF    = 10;
  localparam int HEALTH_W_DEF    = 6;

  localparam int MULT_STEP = 10;
  localparam int MULT_MAX  = 4;

  typedef enum logic [1:0] {
    J_NONE    = 2'd0,
    J_GOOD    = 2'd1,
    J_PERFECT = 2'd2,
    J_MISS    = 2'd3
  } judge_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    FAILED = 2'd2
  } game_state_t;

  // True when zone row 'row' lies within 'tol' rows of the zone centre.
  function automatic logic in_center(input int row, input int zone_w, input int tol);
    return (row >= zone_w / 2 - tol) && (row <= zone_w / 2 + tol);
  endfunction

  // Multiplier earned by a streak: one step per MULT_STEP hits, capped.
  function automatic logic [2:0] mult_of(input logic [31:0] streak_val);
    if (streak_val >= 32'(MULT_STEP * (MULT_MAX - 1)))
      return 3'(MULT_MAX);
    return 3'(32'd1 + streak_val / 32'(MULT_STEP));
  endfunction

endpackage

// File: rtl/lane_judge.sv
// One note lane: key synchroniser with press edge detect, consumed-note shadow
// that falls with the note register, oldest-candidate pick and grading.
module lane_judge
  import rockband_pkg::*;
#(
  parameter int ZONE_W     = ZONE_W_DEF,
  parameter int CENTER_TOL = CENTER_TOL_DEF
) (
  input  logic              frame_clk,
  input  logic              reset_n,
  input  logic              judge_en,
  input  logic              shadow_clr,
  input  logic              key_raw,
  input  logic [ZONE_W-1:0] zone_bits,
  input  logic              exit_bit,
  output judge_t            grade,
  output logic              exit_miss
);

  logic              key_sync1_reg, key_sync2_reg, key_hist_reg;
  logic              press;
  logic [ZONE_W:0]   consumed_reg, consumed_next;
  logic [ZONE_W-1:0] cand, oldest, center_mask;
  logic              any_cand, on_center, take;

  always_ff @(posedge frame_clk or negedge reset_n) begin
    if (!reset_n) begin
      key_sync1_reg <= 1'b0;
      key_sync2_reg <= 1'b0;
      key_hist_reg  <= 1'b0;
      consumed_reg  <= '0;
    end else begin
      key_sync1_reg <= key_raw;
      key_sync2_reg <= key_sync1_reg;
      key_hist_reg  <= key_sync2_reg;
      consumed_reg  <= consumed_next;
    end
  end

  assign press    = key_sync2_reg & ~key_hist_reg;
  assign cand     = zone_bits & ~consumed_reg[ZONE_W-1:0];
  assign any_cand = |cand;

  // Lowest row in the zone holds the oldest note, so the highest candidate wins.
  genvar gi;
  generate
    for (gi = 0; gi < ZONE_W; gi++) begin : g_pick
      assign center_mask[gi] = in_center(gi, ZONE_W, CENTER_TOL);
      if (gi == ZONE_W - 1) begin : g_top
        assign oldest[gi] = cand[gi];
      end else begin : g_rest
        assign oldest[gi] = cand[gi] & ~(|cand[ZONE_W-1:gi+1]);
      end
    end
  endgenerate

  assign on_center = |(oldest & center_mask);
  assign take      = judge_en & press & any_cand;
  assign exit_miss = judge_en & exit_bit & ~consumed_reg[ZONE_W];

  always_comb begin
    grade = J_NONE;
    if (judge_en && press) begin
      if (!any_cand)
        grade = J_MISS;
      else if (on_center)
        grade = J_PERFECT;
      else
        grade = J_GOOD;
    end
  end

  // The struck note moves one row down on this same edge, so mark it one row lower.
  always_comb begin
    consumed_next = {consumed_reg[ZONE_W-1:0], 1'b0};
    if (take)
      consumed_next = consumed_next | {oldest, 1'b0};
    if (shadow_clr)
      consumed_next = '0;
  end

endmodule

// File: rtl/hit_judge.sv
// Strike-zone judge: per-lane grading plus score, streak, multiplier, health
// and game-state tracking. Define MULTIPLIER_EN to enable the streak multiplier.
module hit_judge
  import rockband_pkg::*;
#(
  parameter int ZONE_W      = ZONE_W_DEF,
  parameter int CENTER_TOL  = CENTER_TOL_DEF,
  parameter int PTS_PERFECT = PTS_PERFECT_DEF,
  parameter int PTS_GOOD    = PTS_GOOD_DEF,
  parameter int SCORE_W     = SCORE_W_DEF,
  parameter int STREAK_W    = STREAK_W_DEF,
  parameter int HEALTH_W    = HEALTH_W_DEF
) (
  input  logic                                frame_clk,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic [NUM_LANES-1:0]                keys,
  input  logic [NUM_LANES-1:0][ZONE_W-1:0]    zone_bits,
  input  logic [NUM_LANES-1:0]                exit_bits,
  output logic [SCORE_W-1:0]                  score,
  output logic [STREAK_W-1:0]                 streak,
  output logic [2:0]                          multiplier,
  output logic [HEALTH_W-1:0]                 health,
  output logic [1:0]                          game_state,
  output logic [NUM_LANES-1:0]                hit_flag,
  output logic [NUM_LANES-1:0]                perfect_flag,
  output logic [NUM_LANES-1:0]                miss_flag
);

  localparam int                  HEALTH_MAX  = 2 ** HEALTH_W - 1;
  localparam logic [HEALTH_W-1:0] HEALTH_INIT = HEALTH_W'(HEALTH_MAX / 2);
  localparam logic [SCORE_W-1:0]  SCORE_MAX   = '1;
  localparam logic [STREAK_W-1:0] STREAK_MAX  = '1;
  localparam int CNT_W  = $clog2(2 * NUM_LANES + 1);
  localparam int SUM_W  = (SCORE_W >= 32) ? SCORE_W + 1 : 33;
  localparam int STK_W  = STREAK_W + 1;
  localparam int HC_W   = HEALTH_W + CNT_W + 3;

  game_state_t          state_reg, state_next;
  logic [SCORE_W-1:0]   score_reg, score_next, score_upd;
  logic [STREAK_W-1:0]  streak_reg, streak_next, streak_upd;
  logic [2:0]           mult_reg, mult_next, mult_upd, eff_mult;
  logic [HEALTH_W-1:0]  health_reg, health_next, health_upd;
  logic [NUM_LANES-1:0] hit_reg, hit_next, perf_reg, perf_next, miss_reg, miss_next;

  judge_t               grade [NUM_LANES];
  logic [NUM_LANES-1:0] exit_miss, lane_hit, lane_perf, lane_miss;
  logic                 judge_en, shadow_clr;

  logic [CNT_W-1:0]     hit_cnt, miss_cnt;
  logic [31:0]          base_pts, pts;
  logic [SUM_W-1:0]     score_sum;
  logic [STK_W-1:0]     streak_sum;
  logic [HC_W-1:0]      health_up, health_down, health_diff;

  assign judge_en = (state_reg == PLAY);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      lane_judge #(
        .ZONE_W     (ZONE_W),
        .CENTER_TOL (CENTER_TOL)
      ) u_lane (
        .frame_clk  (frame_clk),
        .reset_n    (reset_n),
        .judge_en   (judge_en),
        .shadow_clr (shadow_clr),
        .key_raw    (keys[gi]),
        .zone_bits  (zone_bits[gi]),
        .exit_bit   (exit_bits[gi]),
        .grade      (grade[gi]),
        .exit_miss  (exit_miss[gi])
      );
      assign lane_hit[gi]  = (grade[gi] == J_GOOD) || (grade[gi] == J_PERFECT);
      assign lane_perf[gi] = (grade[gi] == J_PERFECT);
      assign lane_miss[gi] = (grade[gi] == J_MISS) || exit_miss[gi];
    end
  endgenerate

  // A lane can log a hit and a pass-through miss together; both events count.
  always_comb begin
    hit_cnt  = '0;
    miss_cnt = '0;
    base_pts = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      hit_cnt  = hit_cnt + CNT_W'(lane_hit[l]);
      miss_cnt = miss_cnt + CNT_W'(grade[l] == J_MISS) + CNT_W'(exit_miss[l]);
      if (lane_perf[l])
        base_pts = base_pts + 32'(PTS_PERFECT);
      else if (lane_hit[l])
        base_pts = base_pts + 32'(PTS_GOOD);
    end
  end

`ifdef MULTIPLIER_EN
  assign eff_mult = mult_reg;
  assign mult_upd = mult_of(32'(streak_upd));
`else
  assign eff_mult = 3'd1;
  assign mult_upd = 3'd1;
`endif

  assign pts       = base_pts * {29'd0, eff_mult};
  assign score_sum = SUM_W'(score_reg) + SUM_W'(pts);
  assign score_upd = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];

  assign streak_sum = STK_W'(streak_reg) + STK_W'(hit_cnt);
  assign streak_upd = (miss_cnt != '0)  ? '0 :
                      streak_sum[STREAK_W] ? STREAK_MAX : streak_sum[STREAK_W-1:0];

  assign health_up   = HC_W'(health_reg) + HC_W'(hit_cnt);
  assign health_down = HC_W'({miss_cnt, 2'b00});
  assign health_diff = health_up - health_down;
  assign health_upd  = (health_down >= health_up)        ? '0 :
                       (health_diff > HC_W'(HEALTH_MAX)) ? HEALTH_W'(HEALTH_MAX) :
                                                           health_diff[HEALTH_W-1:0];

  always_ff @(posedge frame_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      score_reg  <= '0;
      streak_reg <= '0;
      mult_reg   <= 3'd1;
      health_reg <= HEALTH_INIT;
      hit_reg    <= '0;
      perf_reg   <= '0;
      miss_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      score_reg  <= score_next;
      streak_reg <= streak_next;
      mult_reg   <= mult_next;
      health_reg <= health_next;
      hit_reg    <= hit_next;
      perf_reg   <= perf_next;
      miss_reg   <= miss_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    score_next  = score_reg;
    streak_next = streak_reg;
    mult_next   = mult_reg;
    health_next = health_reg;
    hit_next    = '0;
    perf_next   = '0;
    miss_next   = '0;
    shadow_clr  = 1'b0;
    case (state_reg)
      PLAY: begin
        score_next  = score_upd;
        streak_next = streak_upd;
        mult_next   = mult_upd;
        health_next = health_upd;
        hit_next    = lane_hit;
        perf_next   = lane_perf;
        miss_next   = lane_miss;
        if (health_upd == '0)
          state_next = FAILED;
      end
      IDLE, FAILED: begin
        if (start) begin
          state_next  = PLAY;
          score_next  = '0;
          streak_next = '0;
          mult_next   = 3'd1;
          health_next = HEALTH_INIT;
          shadow_clr  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign score        = score_reg;
  assign streak       = streak_reg;
  assign multiplier   = mult_reg;
  assign health       = health_reg;
  assign game_state   = state_reg;
  assign hit_flag     = hit_reg;
  assign perfect_flag = perf_reg;
  assign miss_flag    = miss_reg;

endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge: falling-note field driven each frame, a
// position-queue game model compared every frame, plus literal spot checks.
module tb_hit_judge;

  localparam int ZW = 16;
`ifdef MULTIPLIER_EN
  localparam bit MULT_ON = 1'b1;
`else
  localparam bit MULT_ON = 1'b0;
`endif

  logic              frame_clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [3:0]        keys;
  logic [3:0][ZW-1:0] zone_bits;
  logic [3:0]        exit_bits;
  logic [19:0]       score;
  logic [9:0]        streak;
  logic [2:0]        multiplier;
  logic [5:0]        health;
  logic [1:0]        game_state;
  logic [3:0]        hit_flag, perfect_flag, miss_flag;

  logic [3:0][ZW:0]  field;   // rows 0..ZW-1 are the zone, row ZW is the exit row

  int n_checks = 0;
  int n_pass   = 0;
  int nframe   = 0;
  bit cmp_en   = 1'b0;

  always #5 frame_clk = ~frame_clk;

  always_comb begin
    zone_bits = '0;
    exit_bits = '0;
    for (int l = 0; l < 4; l++) begin
      zone_bits[l] = field[l][ZW-1:0];
      exit_bits[l] = field[l][ZW];
    end
  end

  hit_judge dut (
    .frame_clk    (frame_clk),
    .reset_n      (reset_n),
    .start        (start),
    .keys         (keys),
    .zone_bits    (zone_bits),
    .exit_bits    (exit_bits),
    .score        (score),
    .streak       (streak),
    .multiplier   (multiplier),
    .health       (health),
    .game_state   (game_state),
    .hit_flag     (hit_flag),
    .perfect_flag (perfect_flag),
    .miss_flag    (miss_flag)
  );

  // ---------------- behavioural model ----------------
  int         m_state, m_score, m_streak, m_mult, m_health;
  logic [3:0] m_hit, m_perf, m_miss;
  logic [3:0] kq0, kq1, kq2;       // key samples taken 1, 2 and 3 edges ago
  int         cons_q[$];           // consumed notes, encoded lane*64 + row

  function automatic bit is_consumed(input int l, input int r);
    foreach (cons_q[i]) if (cons_q[i] == l * 64 + r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_score = 0; m_streak = 0; m_mult = 1; m_health = 31;
    m_hit = '0; m_perf = '0; m_miss = '0;
    kq0 = '0; kq1 = '0; kq2 = '0;
    cons_q.delete();
  endtask

  task automatic model_edge();
    logic [3:0] press;
    int hits, misses, base, pick;
    int aged[$];
    press = kq1 & ~kq2;
    kq2 = kq1; kq1 = kq0; kq0 = keys;
    m_hit = '0; m_perf = '0; m_miss = '0;
    if (m_state == 1) begin
      hits = 0; misses = 0; base = 0;
      for (int l = 0; l < 4; l++) begin
        if (exit_bits[l] && !is_consumed(l, ZW)) begin
          m_miss[l] = 1'b1; misses++;
        end
        if (press[l]) begin
          pick = -1;
          for (int r = 0; r < ZW; r++)
            if (zone_bits[l][r] && !is_consumed(l, r)) pick = r;
          if (pick < 0) begin
            m_miss[l] = 1'b1; misses++;
          end else begin
            m_hit[l] = 1'b1; hits++;
            cons_q.push_back(l * 64 + pick);
            if ((pick > ZW/2 ? pick - ZW/2 : ZW/2 - pick) <= 3) begin
              m_perf[l] = 1'b1; base += 100;
            end else base += 50;
          end
        end
      end
      m_score += base * (MULT_ON ? m_mult : 1);
      if (m_score > 1048575) m_score = 1048575;
      m_streak = (misses > 0) ? 0 : m_streak + hits;
      if (m_streak > 1023) m_streak = 1023;
      m_mult = MULT_ON ? ((1 + m_streak / 10) > 4 ? 4 : 1 + m_streak / 10) : 1;
      m_health = m_health + hits - 4 * misses;
      if (m_health < 0)  m_health = 0;
      if (m_health > 63) m_health = 63;
      if (m_health == 0) m_state = 2;
    end else if (start) begin
      m_state = 1; m_score = 0; m_streak = 0; m_mult = 1; m_health = 31;
      cons_q.delete();
    end
    // every tracked note falls one row; drop those past the exit row
    foreach (cons_q[i]) if ((cons_q[i] % 64) + 1 <= ZW) aged.push_back(cons_q[i] + 1);
    cons_q = aged;
  endtask

  always @(posedge frame_clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_edge();
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int want);
    n_checks++;
    if (act == want) n_pass++;
    else $display("FAIL %s got=%0d want=%0d (frame %0d)", name, act, want, nframe);
  endtask

  always @(negedge frame_clk) begin
    if (cmp_en) begin
      chk("state",   int'(game_state),   m_state);
      chk("score",   int'(score),        m_score);
      chk("streak",  int'(streak),       m_streak);
      chk("mult",    int'(multiplier),   m_mult);
      chk("health",  int'(health),       m_health);
      chk("hit",     int'(hit_flag),     int'(m_hit));
      chk("perfect", int'(perfect_flag), int'(m_perf));
      chk("miss",    int'(miss_flag),    int'(m_miss));
    end
  end

  // ---------------- stimulus ----------------
  task automatic frame(input logic [3:0] k);
    keys = k;
    @(posedge frame_clk);
    #1;
    for (int l = 0; l < 4; l++) field[l] = field[l] << 1;
    @(negedge frame_clk);
    nframe++;
    $display("frame %0d keys=%b state=%0d score=%0d streak=%0d mult=%0d health=%0d hit=%b perf=%b miss=%b",
             nframe, k, game_state, score, streak, multiplier, health, hit_flag, perfect_flag, miss_flag);
  endtask

  // Note placed two rows early so it sits at 'row' on the judging edge.
  task automatic press_note(input int l, input int row);
    field[l][row-2] = 1'b1;
    frame(4'(1 << l));
    frame(4'(1 << l));
    frame(4'b0000);
  endtask

  task automatic bad_press(input int l);
    frame(4'(1 << l));
    frame(4'b0000);
    frame(4'b0000);
  endtask

  int score_before;

  initial begin
    reset_n = 1'b1; start = 1'b0; keys = '0; field = '0;
    #2 reset_n = 1'b0;
    @(negedge frame_clk);
    cmp_en = 1'b1;
    chk("rst_state", int'(game_state), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_mult", int'(multiplier), 1);
    chk("rst_health", int'(health), 31);
    chk("rst_flags", int'({hit_flag, perfect_flag, miss_flag}), 0);
    @(negedge frame_clk);
    reset_n = 1'b1;

    start = 1'b1; frame(4'b0000); start = 1'b0;
    chk("start_state", int'(game_state), 1);
    chk("start_score", int'(score), 0);
    chk("start_mult", int'(multiplier), 1);
    chk("start_health", int'(health), 31);

    press_note(0, 8);
    chk("perf_flag", int'(perfect_flag), 1);
    chk("perf_score", int'(score), 100);
    chk("perf_streak", int'(streak), 1);

    press_note(1, 14);
    chk("good_hit", int'(hit_flag), 2);
    chk("good_perf", int'(perfect_flag), 0);
    chk("good_score", int'(score), 150);
    frame(4'b0000);
    frame(4'b0000);
    chk("consumed_exit_miss", int'(miss_flag), 0);
    chk("consumed_exit_streak", int'(streak), 2);

    field[2][14] = 1'b1;
    frame(4'b0000); frame(4'b0000); frame(4'b0000);
    chk("pass_miss_flag", int'(miss_flag), 4);
    chk("pass_miss_streak", int'(streak), 0);
    chk("pass_miss_health", int'(health), 29);

    for (int i = 0; i < 10; i++) press_note(3, 8);
    chk("ten_streak", int'(streak), 10);
    chk("ten_mult", int'(multiplier), MULT_ON ? 2 : 1);
    chk("ten_score", int'(score), 1150);
    score_before = int'(score);
    press_note(3, 8);
    chk("eleventh_points", int'(score) - score_before, MULT_ON ? 200 : 100);
    chk("eleventh_health", int'(health), 40);

    // mid-frame asynchronous reset, then a fresh song driven into FAILED
    @(negedge frame_clk);
    #2 reset_n = 1'b0; field = '0; keys = '0;
    @(negedge frame_clk);
    chk("rst2_state", int'(game_state), 0);
    chk("rst2_score", int'(score), 0);
    reset_n = 1'b1;
    start = 1'b1; frame(4'b0000); start = 1'b0;
    for (int i = 0; i < 7; i++) bad_press(2);
    chk("seven_bad_health", int'(health), 3);
    chk("seven_bad_state", int'(game_state), 1);
    bad_press(2);
    chk("fail_health", int'(health), 0);
    chk("fail_state", int'(game_state), 2);
    chk("fail_miss_flag", int'(miss_flag), 4);
    bad_press(2);
    chk("failed_flags", int'({hit_flag, perfect_flag, miss_flag}), 0);
    chk("failed_health", int'(health), 0);
    start = 1'b1; frame(4'b0000); start = 1'b0;
    chk("restart_state", int'(game_state), 1);
    chk("restart_health", int'(health), 31);
    frame(4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
